// File: rtl/uart_dec_tx.sv
// 8N1 UART transmitter that sends an 8-bit value as three ASCII decimal digits,
// optionally followed by CR LF.
module uart_dec_tx #(
  parameter int unsigned BAUD_DIV = 5208,
  parameter bit          CRLF_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NumChars = CRLF_EN ? 5 : 3;
  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  CharLast = 3'(NumChars - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  char_q, char_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept, bit_end, last_char;
  logic [1:0]  hund;
  logic [7:0]  rem;
  logic [3:0]  tens, ones;
  logic [7:0]  cur_char;

  assign accept    = (state_q == StIdle) && tx_start;
  assign bit_end   = (state_q != StIdle) && (baud_q == BaudLast);
  assign last_char = (char_q == CharLast);

  // Combinational conversion from the latched value; settles long before the first data bit.
  always_comb begin
    hund = 2'd0;
    rem  = data_q;
    if (data_q >= 8'd200) begin
      hund = 2'd2;
      rem  = data_q - 8'd200;
    end else if (data_q >= 8'd100) begin
      hund = 2'd1;
      rem  = data_q - 8'd100;
    end
    tens = 4'(rem / 8'd10);
    ones = 4'(rem % 8'd10);
  end

  always_comb begin
    case (char_q)
      3'd0:    cur_char = 8'h30 + {6'd0, hund};
      3'd1:    cur_char = 8'h30 + {4'd0, tens};
      3'd2:    cur_char = 8'h30 + {4'd0, ones};
      3'd3:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tx_start) state_d = StStart;
      StStart: if (bit_end) state_d = StData;
      StData:  if (bit_end && (bit_q == 4'd8)) state_d = StStop;
      StStop:  if (bit_end) state_d = last_char ? StIdle : StStart;
    endcase
  end

  // Bit index 0 is the start bit, 1..8 the data bits, 9 the stop bit.
  always_comb begin
    baud_d = baud_q;
    bit_d  = bit_q;
    char_d = char_q;
    data_d = data_q;
    if (accept) begin
      data_d = tx_data;
      baud_d = '0;
      bit_d  = '0;
      char_d = '0;
    end else if (state_q != StIdle) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          bit_d  = '0;
          char_d = last_char ? 3'd0 : char_q + 3'd1;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end
  end

  // Outputs are computed one cycle ahead and registered so tx is glitch-free.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != StIdle);
    done_d = (state_q == StStop) && bit_end && last_char;
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_char[3'(bit_d - 4'd1)];
      StStop:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q <= '0;
      bit_q  <= '0;
      char_q <= '0;
      data_q <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      char_q <= char_d;
      data_q <= data_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/uart_dec_tx.md
Name: uart_dec_tx

Overview:
- UART transmitter that sends an 8-bit value as ASCII decimal text, optionally followed by CR LF.
- It is the transmit side paired with the receive-and-display path: the receiver path shows a byte on the 7-segment digits, and this block reports a byte back to the host terminal as text.
- Sits between application logic (the byte source) and the board TX pin; 8N1 framing.

Parameters:
- BAUD_DIV, 5208, clocks per bit (50 MHz / 9600). Legal range 4..65535.
- CRLF_EN, 1, 1: append 0x0D 0x0A after the digits (5 chars per message); 0: digits only (3 chars).

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous reset, active low
- tx_start  input  1  request pulse; accepted only when busy=0
- tx_data  input  8  value to send, 0..255, sampled on acceptance
- tx  output  1  serial line, idle high
- busy  output  1  high from the cycle after acceptance until the message completes
- done  output  1  one-cycle pulse when the last stop bit ends

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: tx=1, busy=0, done=0. All counters and the state are cleared, and the state is IDLE.
- Reset asserted mid-message aborts the message immediately: tx=1 and busy=0 asynchronously, and no done pulse follows.
- Acceptance:
  - tx_start=1 at a rising edge with busy=0 latches tx_data into the data register.
  - After that same edge: busy=1, tx=0 (start bit of char 0).
  - tx_start while busy=1 is ignored. Changes to tx_data after acceptance are ignored.
- Digit conversion, from the latched value:
  - H = v/100, T = (v/10)%10, O = v%10.
  - ASCII char = 8'h30 + digit. Leading zeros are always sent (7 -> "007").
  - Conversion must be complete before the first data bit, i.e. within BAUD_DIV cycles of acceptance.
- Character sequence: H, T, O, then 0x0D, 0x0A if CRLF_EN=1. N = 5 or 3 characters.
- Frame:
  - start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Every bit lasts exactly BAUD_DIV cycles.
  - No idle gap between characters: the next start bit begins the cycle after the previous stop bit ends.
- Baud counter: counts 0..BAUD_DIV-1, wraps at BAUD_DIV-1 and advances the bit index. The bit index runs 0..9 and wraps to the next character.
- State machine:
  - IDLE -> START on acceptance.
  - START -> DATA after BAUD_DIV cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if chars remain.
  - STOP -> IDLE after char N-1.
- Completion: if acceptance is at edge k, then at edge k + N*10*BAUD_DIV: state=IDLE, busy=0, done=1 for exactly one cycle, tx=1.
- Back-to-back: tx_start high in the done cycle is accepted (busy=0). The next start bit begins right after that edge, so there is zero idle time between messages.
- tx is driven from a register, so it is glitch-free.

Test Plan (bench uses BAUD_DIV=8):
- Reset, then tx_start with tx_data=8'd123, CRLF_EN=1 -> decoded bytes 0x31 0x32 0x33 0x0D 0x0A. Each bit is 8 cycles, start bit low, stop bit high. done pulses at exactly 400 cycles after acceptance; busy is high for cycles 1..400.
- tx_data=8'd0 then 8'd255 -> "000\r\n" and "255\r\n". Also tx_data=8'd7 -> 0x30 0x30 0x37 0x0D 0x0A.
- Pulse tx_start again and change tx_data to 8'd99 at cycle 50 of a message carrying 8'd42 -> output stays "042\r\n", no second message is sent, and done pulses once.
- Assert rst_n=0 during the data bits of char 1 -> tx=1 and busy=0 immediately, with no done pulse. A subsequent tx_start with 8'd5 sends "005\r\n" cleanly.
- CRLF_EN=0, tx_data=8'd200 -> only 0x32 0x30 0x30 are sent; done pulses at 240 cycles after acceptance.
- Assert tx_start in the done cycle with 8'd18 after a message of 8'd81 -> the second start bit begins the cycle after done with no idle high time. The output is "081\r\n018\r\n" with two done pulses 400 cycles apart.
